// File: rtl/dma_word_copy_pkg.sv
// Shared state encoding, access masks and address step
// for the dma_word_copy engine.
package dma_word_copy_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [3:0] WORD_MASK_DEF = 4'b0111;
  localparam logic [3:0] BYTE_MASK     = 4'b0001;
  localparam logic [3:0] HALF_MASK     = 4'b0011;

  localparam logic [31:0] ADDR_INC = 32'd4;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/dma_word_copy_addr_counter.sv
// Source/destination word pointers plus the remaining-word
// down-counter, loaded together and stepped once per write.
module dma_word_copy_addr_counter
  import dma_word_copy_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [31:0]      src_load,
  input  logic [31:0]      dst_load,
  input  logic [LEN_W-1:0] len_load,
  output logic [31:0]      src_ptr,
  output logic [31:0]      dst_ptr,
  output logic             last
);

  logic [LEN_W-1:0] remaining;

  // load on start, advance both pointers and count down per word
  always_ff @(posedge clk) begin
    if (reset) begin
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
    end else if (load) begin
      src_ptr   <= word_align(src_load);
      dst_ptr   <= word_align(dst_load);
      remaining <= len_load;
    end else if (step) begin
      src_ptr   <= src_ptr + ADDR_INC;
      dst_ptr   <= dst_ptr + ADDR_INC;
      remaining <= remaining - 1'b1;
    end
  end

  assign last = (remaining == LEN_W'(1));

endmodule

// File: rtl/dma_word_copy.sv
// Word copy DMA initiator on the data memory request bus.
// Optional fill mode enabled by DMA_WORD_COPY_FILL_EN.
module dma_word_copy
  import dma_word_copy_pkg::*;
#(
  parameter int         LEN_W     = 16,
  parameter logic [3:0] WORD_MASK = WORD_MASK_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
`ifdef DMA_WORD_COPY_FILL_EN
  input  logic             fill,
  input  logic [31:0]      fill_value,
`endif
  output logic             busy,
  output logic             done,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_write_data,
  output logic             mem_memwrite,
  output logic             mem_memread,
  output logic [3:0]       mem_sign_mask,
  input  logic [31:0]      mem_read_data,
  input  logic             mem_clk_stall
);

  state_t      state;
  state_t      state_next;
  logic        load;
  logic        step;
  logic        capture;
  logic        last;
  logic        stall_seen;
  logic        fill_mode;
  logic        fill_req;
  logic [31:0] fill_word;
  logic [31:0] data_hold;
  logic [31:0] src_ptr;
  logic [31:0] dst_ptr;

`ifdef DMA_WORD_COPY_FILL_EN
  assign fill_req  = fill;
  assign fill_word = fill_value;
`else
  assign fill_req  = 1'b0;
  assign fill_word = '0;
`endif

  dma_word_copy_addr_counter #(
    .LEN_W(LEN_W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .step     (step),
    .src_load (src_addr),
    .dst_load (dst_addr),
    .len_load (len),
    .src_ptr  (src_ptr),
    .dst_ptr  (dst_ptr),
    .last     (last)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // read-data capture, stall tracking and mode latch
  always_ff @(posedge clk) begin
    if (reset) begin
      data_hold  <= '0;
      stall_seen <= 1'b0;
      fill_mode  <= 1'b0;
    end else if (load) begin
      data_hold  <= fill_word;
      stall_seen <= 1'b0;
      fill_mode  <= fill_req;
    end else if (state == RD_WAIT) begin
      if (capture) begin
        data_hold  <= mem_read_data;
        stall_seen <= 1'b0;
      end else if (mem_clk_stall) begin
        stall_seen <= 1'b1;
      end
    end
  end

  // next state and bus request outputs
  always_comb begin
    state_next     = state;
    busy           = 1'b0;
    done           = 1'b0;
    load           = 1'b0;
    step           = 1'b0;
    capture        = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    mem_memread    = 1'b0;
    mem_memwrite   = 1'b0;
    mem_sign_mask  = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load = 1'b1;
          if (len == '0)    state_next = DONE;
          else if (fill_req) state_next = WR_REQ;
          else               state_next = RD_REQ;
        end
      end
      RD_REQ: begin
        busy = 1'b1;
        if (bus_gnt && !mem_clk_stall) begin
          mem_memread   = 1'b1;
          mem_addr      = src_ptr;
          mem_sign_mask = WORD_MASK;
          state_next    = RD_WAIT;
        end
      end
      RD_WAIT: begin
        busy = 1'b1;
        if (stall_seen && !mem_clk_stall) begin
          capture    = 1'b1;
          state_next = WR_REQ;
        end
      end
      WR_REQ: begin
        busy = 1'b1;
        if (bus_gnt) begin
          mem_memwrite   = 1'b1;
          mem_addr       = dst_ptr;
          mem_write_data = data_hold;
          mem_sign_mask  = WORD_MASK;
          step           = 1'b1;
          if (last)          state_next = DONE;
          else if (fill_mode) state_next = WR_REQ;
          else               state_next = RD_REQ;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus_req = busy;

endmodule

// File: tb/tb_dma_word_copy.sv
// Self-checking bench for dma_word_copy: stalling responder,
// array memory and a sequential copy reference model.
module tb_dma_word_copy;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] len;
`ifdef DMA_WORD_COPY_FILL_EN
  logic        fill;
  logic [31:0] fill_value;
`endif
  logic        busy;
  logic        done;
  logic        bus_req;
  logic        bus_gnt;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data = '0;
  logic        mem_clk_stall = 1'b0;

  dma_word_copy #(
    .LEN_W     (16),
    .WORD_MASK (4'b0111)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .src_addr       (src_addr),
    .dst_addr       (dst_addr),
    .len            (len),
`ifdef DMA_WORD_COPY_FILL_EN
    .fill           (fill),
    .fill_value     (fill_value),
`endif
    .busy           (busy),
    .done           (done),
    .bus_req        (bus_req),
    .bus_gnt        (bus_gnt),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_memwrite   (mem_memwrite),
    .mem_memread    (mem_memread),
    .mem_sign_mask  (mem_sign_mask),
    .mem_read_data  (mem_read_data),
    .mem_clk_stall  (mem_clk_stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // responder: memory, stall timing, garbage data during stall
  logic [31:0] mem [1024];
  logic [31:0] rd_addr = '0;
  int          stall_cnt = 0;
  int          stall_len = 1;
  logic        init_go = 1'b0;

  always @(posedge clk) begin
    if (init_go) begin
      for (int i = 0; i < 1024; i++) mem[i] <= $urandom;
    end else begin
      if (stall_cnt != 0) begin
        stall_cnt <= stall_cnt - 1;
        if (stall_cnt == 1) begin
          mem_clk_stall <= 1'b0;
          mem_read_data <= mem[rd_addr[11:2]];
        end
      end else if (mem_memread) begin
        rd_addr       <= mem_addr;
        mem_clk_stall <= 1'b1;
        stall_cnt     <= stall_len;
        mem_read_data <= $urandom;
      end
      if (mem_memwrite) mem[mem_addr[11:2]] <= mem_write_data;
    end
  end

  // bus monitor
  logic [31:0] rd_q[$];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int rd_cyc_q[$];
  int wr_cyc_q[$];
  int done_cnt = 0;
  int done_cyc = 0;
  int busy_cnt = 0;
  int bad_gnt = 0;
  int bad_mask = 0;
  int bad_req = 0;
  int rd_in_stall = 0;

  always @(negedge clk) begin
    if (mem_memread) begin
      rd_q.push_back(mem_addr);
      rd_cyc_q.push_back(cyc);
      if (mem_clk_stall) rd_in_stall <= rd_in_stall + 1;
    end
    if (mem_memwrite) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_write_data);
      wr_cyc_q.push_back(cyc);
    end
    if ((mem_memread || mem_memwrite) && !bus_gnt) bad_gnt <= bad_gnt + 1;
    if ((mem_memread || mem_memwrite) ? (mem_sign_mask !== 4'b0111)
                                      : (mem_sign_mask !== 4'b0000))
      bad_mask <= bad_mask + 1;
    if (bus_req !== busy) bad_req <= bad_req + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model state
  logic [31:0] refm [1024];
  logic [31:0] exp_ra[$];
  logic [31:0] exp_wa[$];
  logic [31:0] exp_wd[$];
  int rb, wb, db, bb;

  task automatic start_copy(input logic [31:0] s, input logic [31:0] d,
                            input int n, input bit f,
                            input logic [31:0] fv, output int sc);
    logic [31:0] ra, wa, v;
    for (int i = 0; i < 1024; i++) refm[i] = mem[i];
    exp_ra.delete();
    exp_wa.delete();
    exp_wd.delete();
    for (int i = 0; i < n; i++) begin
      if (f) begin
        v = fv;
      end else begin
        ra = (s & ~32'h3) + 32'(4 * i);
        exp_ra.push_back(ra);
        v = refm[ra[11:2]];
      end
      wa = (d & ~32'h3) + 32'(4 * i);
      refm[wa[11:2]] = v;
      exp_wa.push_back(wa);
      exp_wd.push_back(v);
    end
    rb = rd_q.size();
    wb = wa_q.size();
    db = done_cnt;
    bb = busy_cnt;
    src_addr = s;
    dst_addr = d;
    len = 16'(n);
`ifdef DMA_WORD_COPY_FILL_EN
    fill = f;
    fill_value = fv;
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    sc = cyc;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (done_cnt == db && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt - db), 32'd1);
    tick();
  endtask

  task automatic verify(input string tag);
    logic [31:0] a;
    check({tag, "_nrd"}, 32'(rd_q.size() - rb), 32'(exp_ra.size()));
    foreach (exp_ra[i])
      if (rb + i < rd_q.size())
        check({tag, "_raddr"}, rd_q[rb + i], exp_ra[i]);
    check({tag, "_nwr"}, 32'(wa_q.size() - wb), 32'(exp_wa.size()));
    foreach (exp_wa[i]) begin
      if (wb + i < wa_q.size()) begin
        check({tag, "_waddr"}, wa_q[wb + i], exp_wa[i]);
        check({tag, "_wdata"}, wd_q[wb + i], exp_wd[i]);
      end
      a = exp_wa[i];
      check({tag, "_mem"}, mem[a[11:2]], exp_wd[i]);
    end
  endtask

  initial begin
    int s, s1, s2, d0, n, sl;
    logic [31:0] sa, da;
    reset = 1'b1;
    start = 1'b0;
    bus_gnt = 1'b1;
    src_addr = '0;
    dst_addr = '0;
    len = '0;
`ifdef DMA_WORD_COPY_FILL_EN
    fill = 1'b0;
    fill_value = '0;
`endif
    init_go = 1'b1;
    tick();
    tick();
    init_go = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_memread", 32'(mem_memread), 32'd0);
    check("rst_memwrite", 32'(mem_memwrite), 32'd0);
    check("rst_mask", 32'(mem_sign_mask), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_write_data, 32'd0);
    reset = 1'b0;
    tick();

    // four word copy, nominal timing
    stall_len = 1;
    start_copy(32'h100, 32'h200, 4, 1'b0, 32'h0, s);
    wait_done("c4", 200);
    verify("c4");
    check("c4_first_rd", 32'(rd_cyc_q[rb]), 32'(s));
    check("c4_done_cyc", 32'(done_cyc - s), 32'd16);
    check("c4_busy_cycles", 32'(busy_cnt - bb), 32'd16);
    tick();

    // zero length
    start_copy(32'h40, 32'h80, 0, 1'b0, 32'h0, s);
    wait_done("len0", 20);
    verify("len0");
    check("len0_done_cyc", 32'(done_cyc - s), 32'd0);
    check("len0_busy", 32'(busy_cnt - bb), 32'd0);
    tick();

    // grant dropped during RD_REQ and during WR_REQ
    bus_gnt = 1'b0;
    start_copy(32'h400, 32'h500, 2, 1'b0, 32'h0, s);
    repeat (3) tick();
    bus_gnt = 1'b1;
    repeat (2) tick();
    bus_gnt = 1'b0;
    repeat (4) tick();
    bus_gnt = 1'b1;
    wait_done("gnt", 200);
    verify("gnt");
    if (rd_q.size() > rb) check("gnt_rd_cyc", 32'(rd_cyc_q[rb] - s), 32'd3);
    if (wa_q.size() > wb) check("gnt_wr_cyc", 32'(wr_cyc_q[wb] - s), 32'd9);
    check("gnt_done_cyc", 32'(done_cyc - s), 32'd14);
    tick();

    // long responder stall
    stall_len = 5;
    start_copy(32'h604, 32'h700, 2, 1'b0, 32'h0, s);
    wait_done("stall5", 200);
    verify("stall5");
    for (int i = 0; i < 2; i++)
      if (rb + i < rd_q.size() && wb + i < wa_q.size())
        check("stall5_rd_to_wr",
              32'(wr_cyc_q[wb + i] - rd_cyc_q[rb + i]), 32'd7);
    repeat (3) tick();

    // reset while in RD_WAIT, responder still stalled
    stall_len = 8;
    d0 = done_cnt;
    start_copy(32'h800, 32'h900, 3, 1'b0, 32'h0, s1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("rstw_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    stall_len = 1;
    start_copy(32'h880, 32'h980, 2, 1'b0, 32'h0, s2);
    wait_done("rstw", 200);
    verify("rstw");
    check("rstw_done_total", 32'(done_cnt - d0), 32'd1);
    if (rd_q.size() > rb) check("rstw_rd_cyc", 32'(rd_cyc_q[rb] - s2), 32'd5);
    repeat (2) tick();

    // randomized copies, unaligned inputs, overlap possible
    for (int t = 0; t < 4; t++) begin
      sa = 32'($urandom_range(0, 32'hE00));
      da = 32'($urandom_range(0, 32'hE00));
      n  = $urandom_range(1, 5);
      sl = $urandom_range(1, 3);
      stall_len = sl;
      start_copy(sa, da, n, 1'b0, 32'h0, s);
      wait_done("rnd", 300);
      verify("rnd");
      check("rnd_done_cyc", 32'(done_cyc - s), 32'(n * (sl + 3)));
      repeat (4) tick();
    end
    stall_len = 1;

`ifdef DMA_WORD_COPY_FILL_EN
    start_copy(32'h0, 32'h300, 3, 1'b1, 32'hDEADBEEF, s);
    wait_done("fill", 50);
    verify("fill");
    for (int i = 0; i < 3; i++)
      if (wb + i < wr_cyc_q.size())
        check("fill_wr_cyc", 32'(wr_cyc_q[wb + i] - s), 32'(i));
    check("fill_done_cyc", 32'(done_cyc - s), 32'd3);
    tick();
`endif

    check("bus_gnt_respected", 32'(bad_gnt), 32'd0);
    check("sign_mask_rule", 32'(bad_mask), 32'd0);
    check("bus_req_eq_busy", 32'(bad_req), 32'd0);
    check("no_read_in_stall", 32'(rd_in_stall), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
